// File: rtl/zigzag_pkg.sv
// ---------------------------------------------------------------------------
// zigzag_pkg
// Shared definitions for the rail-fence encryptor and decryptor:
//   - state_e        : controller states (COLLECT, EMIT, DONE)
//   - KEY_RAIL2/3    : key values that select the 2- and 3-rail mappings
//   - DEFAULT_TOKEN  : in-band character that starts encryption
// ---------------------------------------------------------------------------
package zigzag_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int unsigned KEY_RAIL2 = 2;
  localparam int unsigned KEY_RAIL3 = 3;

  localparam logic [7:0] DEFAULT_TOKEN = 8'hFA;

endpackage

// File: rtl/zigzag_encryption_if.sv
// ---------------------------------------------------------------------------
// zigzag_encryption_if
// Character stream bundle between a plaintext source and the encryptor.
//   data_i/valid_i/key : plaintext character, qualifier, rail count
//   busy/data_o/valid_o: ciphertext emission status and output stream
// master = source / sink side, slave = encryptor side.
// ---------------------------------------------------------------------------
interface zigzag_encryption_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 16
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;

  modport master (
    output data_i, valid_i, key,
    input  busy, data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, key,
    output busy, data_o, valid_o
  );
endinterface

// File: rtl/zigzag_index_map.sv
// ---------------------------------------------------------------------------
// zigzag_index_map
// Combinational map from ciphertext position p to plaintext buffer index src
// for a message of n characters.
//   n_i   : message length
//   key_i : rail count (2 or 3 select a zigzag, anything else passes through)
//   p_i   : ciphertext position, 0 .. n-1
//   src_o : plaintext index to read
// ---------------------------------------------------------------------------
module zigzag_index_map
  import zigzag_pkg::*;
#(
  parameter int KEY_WIDTH = 16
) (
  input  logic [KEY_WIDTH-1:0] n_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [KEY_WIDTH-1:0] p_i,
  output logic [KEY_WIDTH-1:0] src_o
);

  // Rail sizes. Two rails: even positions then odd positions.
  // Three rails: row 0 holds every 4th char, row 1 every odd char, row 2 the
  // chars at 4k+2.
  logic [KEY_WIDTH-1:0] r2_c0;
  logic [KEY_WIDTH-1:0] r3_c0;
  logic [KEY_WIDTH-1:0] r3_c1;

  assign r2_c0 = (n_i + KEY_WIDTH'(1)) >> 1;
  assign r3_c0 = (n_i + KEY_WIDTH'(3)) >> 2;
  assign r3_c1 = n_i >> 1;

  always_comb begin
    src_o = p_i;
    if (key_i == KEY_WIDTH'(KEY_RAIL2)) begin
      if (p_i < r2_c0) src_o = p_i << 1;
      else             src_o = ((p_i - r2_c0) << 1) + KEY_WIDTH'(1);
    end else if (key_i == KEY_WIDTH'(KEY_RAIL3)) begin
      if (p_i < r3_c0)                src_o = p_i << 2;
      else if (p_i < r3_c0 + r3_c1)   src_o = ((p_i - r3_c0) << 1) + KEY_WIDTH'(1);
      else                            src_o = ((p_i - r3_c0 - r3_c1) << 2) + KEY_WIDTH'(2);
    end
  end

endmodule

// File: rtl/zigzag_encryption.sv
// ---------------------------------------------------------------------------
// zigzag_encryption
// Rail-fence encryptor. Buffers plaintext until the start token arrives,
// then streams the ciphertext one character per clock.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : zigzag_encryption_if.slave
//           in : data_i, valid_i, key (sampled on the token cycle)
//           out: busy, data_o, valid_o (data_o is 0 whenever valid_o is 0)
// ---------------------------------------------------------------------------
module zigzag_encryption
  import zigzag_pkg::*;
#(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 16,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = D_WIDTH'(DEFAULT_TOKEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  zigzag_encryption_if.slave   bus
);

  localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] n_q, n_d;
  logic [KEY_WIDTH-1:0] idx_q, idx_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [D_WIDTH-1:0]   data_q, data_d;

  logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
  logic                 buf_we;
  logic                 buf_clr;
  logic [AW-1:0]        buf_wa;

  logic [KEY_WIDTH-1:0] src;
  logic [AW-1:0]        src_a;

  zigzag_index_map #(.KEY_WIDTH(KEY_WIDTH)) u_map (
    .n_i   (n_q),
    .key_i (key_q),
    .p_i   (idx_q),
    .src_o (src)
  );

  // src < n <= MAX_NOF_CHARS, so only the low AW bits are meaningful.
  assign src_a  = src[AW-1:0];
  assign buf_wa = n_q[AW-1:0];

  logic unused_src_hi;
  assign unused_src_hi = &{1'b0, src};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    key_d   = key_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    buf_we  = 1'b0;
    buf_clr = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (bus.valid_i) begin
          if (bus.data_i == START_ENCRYPTION_TOKEN) begin
            key_d   = bus.key;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_EMIT;
          end else if (n_q < KEY_WIDTH'(MAX_NOF_CHARS)) begin
            buf_we = 1'b1;
            n_d    = n_q + KEY_WIDTH'(1);
          end
        end
      end
      ST_EMIT: begin
        if (idx_q < n_q) begin
          valid_d = 1'b1;
          data_d  = buf_q[src_a];
          idx_d   = idx_q + KEY_WIDTH'(1);
        end else begin
          valid_d = 1'b0;
          data_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        n_d     = '0;
        idx_d   = '0;
        buf_clr = 1'b1;
        state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      n_q     <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Buffer is cleared between messages so a short message never exposes
  // characters left over from a longer one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_NOF_CHARS; i++) begin
      if (!rst_n || buf_clr)
        buf_q[i] <= '0;
      else if (buf_we && buf_wa == AW'(i))
        buf_q[i] <= bus.data_i;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;

endmodule
